alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares the single 32-bit ALU datapath between NUM_REQ requesters, using round-robin arbitration.
- Each accepted request is latched, executed in one ALU cycle, and returned on a single registered response channel tagged with the requester index.
- Sits between the requesting units and the shared ALU. Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: requester index width; must equal clog2(NUM_REQ).
- DATA_W, 32: operand/result width; fixed at 32 to match the ALU.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op_i  input  6*NUM_REQ  packed opcodes; requester i uses bits [6i+5:6i].
- req_a_i  input  32*NUM_REQ  packed operand A (ALU in0).
- req_b_i  input  32*NUM_REQ  packed operand B (ALU in1).
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumer ready.
- rsp_id_o  output  ID_W  index of the requester that owns the response.
- rsp_data_o  output  32  result.
- rsp_err_o  output  1  opcode was unsupported (op > 5).
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 SRL: a>>b, logical.
  - 5 SLL: a<<b.
- Arithmetic rules:
  - ADD and SUB are modulo 2^32; carry and borrow are discarded.
  - Shifts use the full 32-bit b; a shift amount >= 32 yields 0.
  - Op 6..63: rsp_data=0, rsp_err=1.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid is high, grant one requester. The grant sets req_ready_o[g]=1 combinationally in the same cycle. At the clock edge, latch op, a, b and id g, then go to EXEC. If no request is valid, stay in IDLE with req_ready_o=0.
  - EXEC: register the ALU output into rsp_data, set rsp_err, go to RESP. req_ready_o=0.
  - RESP: hold rsp_valid_o=1 with data, id and err stable. When rsp_ready_i=1, go to IDLE.
- No new request is accepted in the RESP-exit cycle. The next grant occurs in IDLE at the earliest, so back-to-back throughput is one op per 3 cycles.
- Latency: accepted at edge N; rsp_valid_o rises after edge N+1 (visible in cycle N+1→N+2).
- Round-robin arbitration:
  - A pointer ptr (ID_W bits) is reset to 0.
  - The grant goes to the first valid requester found scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On acceptance, ptr = (g+1) mod NUM_REQ.
  - ptr is unchanged when nothing is granted.
- Requester rules:
  - A requester must hold valid and its operands stable until it sees ready.
  - Dropping valid before ready is permitted; no grant is recorded.
- Backpressure: rsp_ready_i low in RESP holds all response outputs indefinitely.
- Reset (sync, any state, including mid-EXEC or RESP):
  - State is forced to IDLE and ptr to 0.
  - rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0, req_ready_o=0.
  - Any in-flight operation is dropped without a response.
- rsp_valid_o, rsp_data_o, rsp_id_o and rsp_err_o are registered outputs. req_ready_o is combinational from state, ptr and req_valid_i only; it has no combinational path from rsp_ready_i.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SRL=4, OP_SLL=5, OP_LAST=5.
  - The FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Natural sub-module: rr_arbiter (NUM_REQ parameter). Inputs: req vector, ptr, enable. Outputs: one-hot grant and encoded index.
- The scheduler instantiates the existing 32-bit ALU for the datapath, plus rr_arbiter.

Test Plan:
- Reset then single request: req0 ADD a=5, b=7 → req_ready_o=0001 in the request cycle; rsp_valid_o high 2 cycles later with id=0, data=12, err=0.
- All four requesters valid continuously, rsp_ready_i=1 → grants in order 0,1,2,3,0 at 3-cycle spacing. Requesters use SUB 3-5, AND F0&3C, SLL 1<<31 and SRL 80000000>>31; responses FFFFFFFE, 00000030, 80000000, 00000001 with ids 0..3.
- Shift boundary: SLL a=1, b=32 → 0; SRL a=FFFFFFFF, b=0 → FFFFFFFF. Invalid op=7 → data=0, err=1.
- Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP with req2 valid → response outputs stable, req_ready_o stays 0; req2 is granted in the IDLE cycle after the release.
- Round-robin fairness: req1 and req3 valid after ptr=2 → req3 is granted first, then req1.
- rst_i asserted during EXEC → the next cycle shows IDLE with all outputs 0 and no response; the following request from req1 only is granted with ptr starting at 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcodes, FSM encoding and latched-request layout for the round-robin ALU scheduler.
// No latency or backpressure of its own; it holds definitions only.
package alu_pkg;

  localparam int OP_W     = 6;
  localparam int ALU_W    = 32;

  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_AND  = 6'd2;
  localparam logic [OP_W-1:0] OP_OR   = 6'd3;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd5;
  localparam logic [OP_W-1:0] OP_LAST = 6'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu32.sv
// Shared 32-bit ALU: ADD/SUB/AND/OR/SRL/SLL; opcodes above OP_LAST give 0 with err set.
// Purely combinational, so no latency and no backpressure.
module alu32
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             err
);

  // Any set bit above bit 4 means a shift of 32 or more, which clears the result.
  logic shift_oob;
  assign shift_oob = |b[ALU_W-1:5];

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SRL: result = shift_oob ? '0 : (a >> b[4:0]);
      OP_SLL: result = shift_oob ? '0 : (a << b[4:0]);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first asserted request at or after ptr, returned one-hot and encoded.
// Combinational; grant is zero when en is low or nothing is requesting.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NUM_REQ requesters round-robin; accept -> registered response two edges later.
// One op in flight; the response is held while rsp_ready_i is low and no request is accepted meanwhile.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [OP_W*NUM_REQ-1:0]   req_op_i,
  input  logic [DATA_W*NUM_REQ-1:0] req_a_i,
  input  logic [DATA_W*NUM_REQ-1:0] req_b_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      busy_o
);

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      cur_id;
  logic [NUM_REQ-1:0]   grant;
  alu_req_t             cur;
  logic [ALU_W-1:0]     alu_res;
  logic                 alu_err;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (grant),
    .idx   (grant_idx)
  );

  alu32 u_alu (
    .op     (cur.op),
    .a      (cur.a),
    .b      (cur.b),
    .result (alu_res),
    .err    (alu_err)
  );

  // Ready depends only on state, ptr and valids, never on the response side.
  assign req_ready_o = grant;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      cur         <= '0;
      cur_id      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            cur.op <= req_op_i[OP_W*int'(grant_idx) +: OP_W];
            cur.a  <= req_a_i[DATA_W*int'(grant_idx) +: DATA_W];
            cur.b  <= req_b_i[DATA_W*int'(grant_idx) +: DATA_W];
            cur_id <= grant_idx;
            if (int'(grant_idx) == NUM_REQ - 1) ptr <= '0;
            else                                ptr <= grant_idx + ID_W'(1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_o  <= alu_res;
          rsp_err_o   <= alu_err;
          rsp_id_o    <= cur_id;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: per-requester op queues drive the DUT, a cycle-level
// reference model is compared every cycle, and hand-computed literals pin key scenarios.
module tb_alu_rr_scheduler;

  localparam int N = 4;

  typedef struct { logic [5:0] op; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { int id; int cyc; logic [N-1:0] vec; } gnt_t;
  typedef struct { int id; logic [31:0] data; logic err; int cyc; } rsp_t;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [6*N-1:0]  req_op = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            busy;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NUM_REQ(N), .ID_W(2), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  op_t  q[N][$];
  gnt_t grant_log[$];
  rsp_t rsp_log[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  logic [N-1:0] acc = '0;

  // Reference model: free / computing / holding-response, plus the rotating priority.
  int          m_phase = 0;
  int          m_ptr = 0;
  int          m_id = 0, p_id = 0;
  logic [31:0] m_data = '0, p_data = '0;
  logic        m_err = 1'b0, p_err = 1'b0;

  function automatic void alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic e);
    e = 1'b0;
    d = '0;
    case (op)
      6'd0: d = a + b;
      6'd1: d = a - b;
      6'd2: d = a & b;
      6'd3: d = a | b;
      6'd4: d = (b >= 32) ? 32'd0 : (a >> b);
      6'd5: d = (b >= 32) ? 32'd0 : (a << b);
      default: e = 1'b1;
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Compare against the model, log observed traffic, then advance the model.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    if (started) begin
      g = (m_phase == 0) ? rr_pick(req_valid, m_ptr) : -1;
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("model_req_ready", req_ready, exp_rdy);
      chk("model_busy", busy, m_phase != 0);
      chk("model_rsp_valid", rsp_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("model_rsp_id", rsp_id, m_id);
        chk("model_rsp_data", rsp_data, m_data);
        chk("model_rsp_err", rsp_err, m_err);
      end
      if (req_ready != '0) grant_log.push_back('{onehot_idx(req_ready), cyc, req_ready});
      if (rsp_valid && rsp_ready) rsp_log.push_back('{int'(rsp_id), rsp_data, rsp_err, cyc});
      acc = req_ready & req_valid;
      if (rst_i) begin
        m_phase = 0; m_ptr = 0; m_id = 0; m_data = '0; m_err = 1'b0;
      end else begin
        case (m_phase)
          0: if (g >= 0) begin
            m_ptr = (g + 1) % N;
            alu_ref(req_op[6*g +: 6], req_a[32*g +: 32], req_b[32*g +: 32], p_data, p_err);
            p_id = g;
            m_phase = 1;
          end
          1: begin
            m_id = p_id; m_data = p_data; m_err = p_err; m_phase = 2;
          end
          default: if (rsp_ready) m_phase = 0;
        endcase
      end
    end
  end

  // Requesters: present the queue head, hold it until accepted, then move on.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && q[i].size() > 0) q[i].delete(0);
      if (q[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_op[6*i +: 6]    = q[i][0].op;
        req_a[32*i +: 32]   = q[i][0].a;
        req_b[32*i +: 32]   = q[i][0].b;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  task automatic push(input int i, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    q[i].push_back('{op, a, b});
  endtask

  task automatic clear_logs();
    @(posedge clk);
    grant_log.delete();
    rsp_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int k = 0;
    while (rsp_log.size() < n && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk(nm, rsp_log.size(), n);
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_id"}, rsp_id, 0);
    chk({nm, "_rsp_data"}, rsp_data, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_req_ready"}, req_ready, 0);
  endtask

  int          exp_id[5]  = '{0, 1, 2, 3, 0};
  logic [31:0] exp_dat[5] = '{32'hFFFF_FFFE, 32'h0000_0030, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    started = 1'b1;

    // Reset state, then a single ADD from requester 0.
    @(negedge clk);
    chk_idle_zero("reset");
    push(0, 6'd0, 32'd5, 32'd7);
    wait_rsp(1, "single_count");
    chk("single_grant_vec", grant_log[0].vec, 4'b0001);
    chk("single_rsp_id", rsp_log[0].id, 0);
    chk("single_rsp_data", rsp_log[0].data, 32'd12);
    chk("single_rsp_err", rsp_log[0].err, 0);
    chk("single_latency", rsp_log[0].cyc - grant_log[0].cyc, 2);

    // All four requesters busy from a fresh pointer.
    do_reset();
    clear_logs();
    @(negedge clk);
    push(0, 6'd1, 32'd3, 32'd5);
    push(0, 6'd0, 32'd1, 32'd1);
    push(1, 6'd2, 32'hF0, 32'h3C);
    push(2, 6'd5, 32'd1, 32'd31);
    push(3, 6'd4, 32'h8000_0000, 32'd31);
    wait_rsp(5, "rr_count");
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant_id", grant_log[i].id, exp_id[i]);
      chk("rr_rsp_id", rsp_log[i].id, exp_id[i]);
      chk("rr_rsp_data", rsp_log[i].data, exp_dat[i]);
    end
    for (int i = 0; i < 4; i++)
      chk("rr_spacing", grant_log[i+1].cyc - grant_log[i].cyc, 3);

    // Shift boundaries and an unsupported opcode.
    clear_logs();
    @(negedge clk);
    push(0, 6'd5, 32'd1, 32'd32);
    push(0, 6'd4, 32'hFFFF_FFFF, 32'd0);
    push(0, 6'd7, 32'd3, 32'd4);
    wait_rsp(3, "bound_count");
    chk("sll32_data", rsp_log[0].data, 32'd0);
    chk("srl0_data", rsp_log[1].data, 32'hFFFF_FFFF);
    chk("badop_data", rsp_log[2].data, 32'd0);
    chk("badop_err", rsp_log[2].err, 1);
    chk("sll32_err", rsp_log[0].err, 0);

    // Response backpressure with requester 2 waiting.
    clear_logs();
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    push(0, 6'd0, 32'd10, 32'd20);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    push(2, 6'd3, 32'h0F00, 32'h00F0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 32'd30);
      chk("bp_rsp_id", rsp_id, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_rsp(2, "bp_count");
    chk("bp_next_grant_id", grant_log[1].id, 2);
    chk("bp_next_grant_cyc", grant_log[1].cyc - rsp_log[0].cyc, 1);
    chk("bp_next_data", rsp_log[1].data, 32'h0FF0);

    // Fairness: after requester 1 is served, 3 beats 1.
    clear_logs();
    @(negedge clk);
    push(1, 6'd0, 32'd2, 32'd3);
    wait_rsp(1, "fair_pre_count");
    chk("fair_pre_id", grant_log[0].id, 1);
    clear_logs();
    @(negedge clk);
    push(1, 6'd0, 32'd4, 32'd4);
    push(3, 6'd1, 32'd9, 32'd4);
    wait_rsp(2, "fair_count");
    chk("fair_first", grant_log[0].id, 3);
    chk("fair_second", grant_log[1].id, 1);
    chk("fair_first_data", rsp_log[0].data, 32'd5);
    chk("fair_second_data", rsp_log[1].data, 32'd8);

    // Reset while an op is executing drops it.
    clear_logs();
    @(negedge clk);
    push(2, 6'd0, 32'd1, 32'd2);
    k = 0;
    while (req_ready == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_grant_seen", req_ready, 4'b0100);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk_idle_zero("midrst");
    repeat (4) @(posedge clk);
    chk("midrst_no_rsp", rsp_log.size(), 0);
    clear_logs();
    @(negedge clk);
    push(1, 6'd0, 32'd6, 32'd6);
    wait_rsp(1, "postrst_count");
    chk("postrst_grant_id", grant_log[0].id, 1);
    chk("postrst_rsp_data", rsp_log[0].data, 32'd12);

    // Fresh pointer: requester 1 must win over 3.
    do_reset();
    clear_logs();
    @(negedge clk);
    push(1, 6'd0, 32'd0, 32'd1);
    push(3, 6'd0, 32'd0, 32'd3);
    wait_rsp(2, "ptr0_count");
    chk("ptr0_first", grant_log[0].id, 1);
    chk("ptr0_second", grant_log[1].id, 3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
